// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: PC, fixed one-cycle instruction memory reads, 2-entry in-order queue to decode.
// Optional macro IFETCH_B_PREDECODE_EN: unconditional B is detected on return and redirected in fetch.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_pred_taken
);

  logic [31:0] r_pc;
  logic [1:0]  r_count;
  logic        r_head;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic [31:0] r_q_instr [2];
  logic [31:0] r_q_pc    [2];

  logic        w_pop;
  logic        w_push;
  logic        w_wr_idx;
  logic        w_br_hit;
  logic [31:0] w_br_target;
  logic [31:0] w_redirect_pc;
  logic [2:0]  w_occupancy;
  logic [1:0]  w_wr_en;

  assign w_pop         = instr_valid & instr_ready;
  assign w_push        = r_inflight & ~redirect_valid;
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
  // A full queue is never written, so head + count modulo 2 is the free slot.
  assign w_wr_idx      = r_head ^ r_count[0];
  assign w_occupancy   = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};

`ifdef IFETCH_B_PREDECODE_EN
  logic r_q_pt [2];

  assign w_br_hit    = w_push & (imem_rdata[31:26] == 6'b000101);
  assign w_br_target = r_inflight_pc + {{4{imem_rdata[25]}}, imem_rdata[25:0], 2'b00};
  assign instr_pred_taken = r_q_pt[r_head];
`else
  assign w_br_hit    = 1'b0;
  assign w_br_target = r_inflight_pc;
  assign instr_pred_taken = 1'b0;
`endif

  // A predecoded B suppresses this cycle's sequential request instead of killing it later.
  assign imem_req    = ~reset & ~redirect_valid & ~w_br_hit & (w_occupancy < 3'd2);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_count != 2'd0);
  assign instr       = r_q_instr[r_head];
  assign instr_pc    = r_q_pc[r_head];

  for (genvar gi = 0; gi < 2; gi++) begin : g_wr_en
    assign w_wr_en[gi] = w_push & (w_wr_idx == 1'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
`ifdef IFETCH_B_PREDECODE_EN
        r_q_pt[i]    <= 1'b0;
`endif
      end else if (w_wr_en[i]) begin
        r_q_instr[i] <= imem_rdata;
        r_q_pc[i]    <= r_inflight_pc;
`ifdef IFETCH_B_PREDECODE_EN
        r_q_pt[i]    <= w_br_hit;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_count       <= 2'd0;
      r_head        <= 1'b0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= w_redirect_pc;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      if (w_br_hit) begin
        r_pc <= w_br_target;
      end else if (imem_req) begin
        r_pc          <= r_pc + 32'd4;
        r_inflight_pc <= r_pc;
      end
      r_head  <= r_head ^ w_pop;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus queues expected deliveries, monitors pop and compare.
// Expected B handling follows IFETCH_B_PREDECODE_EN.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, instr_valid, instr_pred_taken;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc;

  logic        w_reset, w_redirect_valid, w_ready;
  logic [31:0] w_redirect_pc;
  logic        w_imem_req, w_valid, w_pt;
  logic [31:0] w_imem_addr, w_imem_rdata, w_instr, w_instr_pc;

  bit b_word_en = 1'b0;
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pt;
  } exp_t;
  exp_t exp_q[$];
  exp_t wexp_q[$];

`ifdef IFETCH_B_PREDECODE_EN
  localparam bit PREDECODE = 1'b1;
`else
  localparam bit PREDECODE = 1'b0;
`endif

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pred_taken(instr_pred_taken)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(w_reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .instr_valid(w_valid), .instr_ready(w_ready), .instr(w_instr),
    .instr_pc(w_instr_pc), .instr_pred_taken(w_pt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (b_word_en && a == 32'h0000_0024) return 32'h1400_0002;
    return 32'hB400_0000 + (a >> 2);
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
    if (w_imem_req) w_imem_rdata <= mem_word(w_imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Decoder-side monitor for the main instance; pops killed by a redirect are not retired.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && instr_valid && instr_ready && !redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop actual pc=%h instr=%h required none", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if (instr !== e.instr || instr_pc !== e.pc || instr_pred_taken !== e.pt) begin
          failures++;
          $display("FAIL pop actual pc=%h instr=%h pt=%b required pc=%h instr=%h pt=%b",
                   instr_pc, instr, instr_pred_taken, e.pc, e.instr, e.pt);
        end else begin
          $display("pop pc=%h instr=%h pt=%b ok", instr_pc, instr, instr_pred_taken);
        end
      end
    end
    // A response landing in a full queue without a pop would overflow it.
    if (!reset && dut.r_inflight && !redirect_valid) begin
      checks++;
      if (dut.r_count == 2'd2 && !(instr_valid && instr_ready)) begin
        failures++;
        $display("FAIL queue_overflow actual count=2 with push required room");
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!w_reset && w_valid && w_ready) begin
      checks++;
      if (wexp_q.size() == 0) begin
        failures++;
        $display("FAIL wrap_unexpected_pop actual pc=%h required none", w_instr_pc);
      end else begin
        e = wexp_q.pop_front();
        if (w_instr !== e.instr || w_instr_pc !== e.pc || w_pt !== e.pt) begin
          failures++;
          $display("FAIL wrap_pop actual pc=%h instr=%h pt=%b required pc=%h instr=%h pt=%b",
                   w_instr_pc, w_instr, w_pt, e.pc, e.instr, e.pt);
        end else begin
          $display("wrap pop pc=%h instr=%h ok", w_instr_pc, w_instr);
        end
      end
    end
  end

  task automatic push_exp(input int sel, input logic [31:0] ins, input logic [31:0] pc, input logic pt);
    exp_t e;
    e.instr = ins;
    e.pc    = pc;
    e.pt    = pt;
    if (sel == 0) exp_q.push_back(e);
    else wexp_q.push_back(e);
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? exp_q.size() : wexp_q.size();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until every queued expectation has been delivered, then stop accepting.
  task automatic wait_drain(input int sel, input int budget, input string name, output int n);
    n = 0;
    while (qsize(sel) != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (qsize(sel) != 0) begin
      failures++;
      $display("FAIL %s_timeout actual undelivered=%0d required 0", name, qsize(sel));
      if (sel == 0) exp_q.delete();
      else wexp_q.delete();
    end
    if (sel == 0) instr_ready = 1'b0;
    else w_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    exp_q.delete();
    step();
    step();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0000_0000);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_pred_taken", 32'(instr_pred_taken), 32'd0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    w_reset = 1'b1;
    w_ready = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc = '0;

    // Cold start, streaming at one instruction per cycle.
    do_reset();
    instr_ready = 1'b1;
    check("c0_imem_req", 32'(imem_req), 32'd1);
    check("c0_imem_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) push_exp(0, 32'hB400_0000 + i, 32'(i * 4), 1'b0);
    step();
    check("c1_instr_valid", 32'(instr_valid), 32'd0);
    step();
    check("c2_instr_valid", 32'(instr_valid), 32'd1);
    check("c2_instr_pc", instr_pc, 32'h0);
    wait_drain(0, 20, "stream", n);
    check("stream_cycles", 32'(n), 32'd4);

    // Decoder stall: queue fills, requests stop, head is held.
    do_reset();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", instr_pc, 32'h0);
      check("stall_instr", instr, 32'hB400_0000);
      if (i == 4) check("stall_imem_req", 32'(imem_req), 32'd0);
      if (i < 4) step();
    end
    step();
    for (int i = 0; i < 3; i++) push_exp(0, 32'hB400_0000 + i, 32'(i * 4), 1'b0);
    instr_ready = 1'b1;
    wait_drain(0, 20, "stall_release", n);
    check("stall_release_cycles", 32'(n), 32'd3);

    // Redirect with an entry queued and a response in flight; low bits are dropped.
    do_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_002B;
    #1;
    check("redir_n_imem_req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("redir_n1_valid", 32'(instr_valid), 32'd0);
    check("redir_n1_imem_req", 32'(imem_req), 32'd1);
    check("redir_n1_imem_addr", imem_addr, 32'h0000_0028);
    step();
    check("redir_n2_valid", 32'(instr_valid), 32'd0);
    step();
    check("redir_n3_valid", 32'(instr_valid), 32'd1);
    check("redir_n3_pc", instr_pc, 32'h0000_0028);
    push_exp(0, 32'hB400_000A, 32'h28, 1'b0);
    push_exp(0, 32'hB400_000B, 32'h2C, 1'b0);
    instr_ready = 1'b1;
    wait_drain(0, 20, "redirect", n);

    // Redirect coinciding with a pop and a returning response.
    do_reset();
    instr_ready = 1'b1;
    push_exp(0, 32'hB400_0000, 32'h0, 1'b0);
    step();
    step();
    step();
    check("redir_pop_head_pc", instr_pc, 32'h0000_0004);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    push_exp(0, 32'hB400_0010, 32'h40, 1'b0);
    push_exp(0, 32'hB400_0011, 32'h44, 1'b0);
    step();
    redirect_valid = 1'b0;
    wait_drain(0, 20, "redirect_pop", n);

    // Unconditional B at 0x24 with offset +8.
    b_word_en = 1'b1;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) push_exp(0, 32'hB400_0000 + i, 32'(i * 4), 1'b0);
    push_exp(0, 32'h1400_0002, 32'h24, PREDECODE);
    if (PREDECODE) begin
      push_exp(0, 32'hB400_000B, 32'h2C, 1'b0);
      push_exp(0, 32'hB400_000C, 32'h30, 1'b0);
    end else begin
      push_exp(0, 32'hB400_000A, 32'h28, 1'b0);
      push_exp(0, 32'hB400_000B, 32'h2C, 1'b0);
    end
    wait_drain(0, 40, "branch", n);
    b_word_en = 1'b0;
    reset = 1'b1;

    // PC wrap from the top of the address space.
    check("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFF8);
    check("wrap_rst_valid", 32'(w_valid), 32'd0);
    push_exp(1, 32'hF3FF_FFFE, 32'hFFFF_FFF8, 1'b0);
    push_exp(1, 32'hF3FF_FFFF, 32'hFFFF_FFFC, 1'b0);
    push_exp(1, 32'hB400_0000, 32'h0000_0000, 1'b0);
    w_ready = 1'b1;
    w_reset = 1'b0;
    wait_drain(1, 20, "wrap", n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
